// File: rtl/comparador_umbral_hist_pkg.sv
// Shared types for the threshold comparator: per-channel filter states and
// the persistence-counter width helper.
package comparador_pkg;

  typedef enum logic [1:0] {
    FRIO     = 2'b00,
    SUBIENDO = 2'b01,
    CALIENTE = 2'b11,
    BAJANDO  = 2'b10
  } estado_t;

  function automatic int cnt_w(input int persist);
    return $clog2(persist + 1);
  endfunction

endpackage

// File: rtl/comparador_umbral_hist_if.sv
// Sample/threshold bus between the temperature sampler and the comparator,
// plus the filtered flags going to fan/alarm control.
interface comparador_umbral_hist_if #(
  parameter int ANCHO     = 3,
  parameter int N_CANALES = 2
);
  logic                         muestra_valida;
  logic [N_CANALES*ANCHO-1:0]   temp;
  logic [ANCHO-1:0]             umbral_alto;
  logic [ANCHO-1:0]             umbral_bajo;
  logic                         borrar_sticky;
  logic [N_CANALES-1:0]         Dato_comp;
  logic [N_CANALES-1:0]         sticky;
  logic                         cualquiera;
  logic                         evento;

  modport master (
    output muestra_valida, temp, umbral_alto, umbral_bajo, borrar_sticky,
    input  Dato_comp, sticky, cualquiera, evento
  );

  modport slave (
    input  muestra_valida, temp, umbral_alto, umbral_bajo, borrar_sticky,
    output Dato_comp, sticky, cualquiera, evento
  );
endinterface

// File: rtl/comparador_umbral_hist_canal.sv
// One channel: hysteresis FSM with persistence counter and sticky bit.
// The hot flag is bit 1 of the state register, so it is registered for free.
module canal_histeresis
  import comparador_pkg::*;
#(
  parameter int ANCHO          = 3,
  parameter int CUENTA_PERSIST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valida,
  input  logic [ANCHO-1:0] temp,
  input  logic [ANCHO-1:0] alto,
  input  logic [ANCHO-1:0] bajo_ef,
  input  logic             borrar,
  output logic             dato,
  output logic             dato_nxt,
  output logic             sticky
);
  localparam int CW = cnt_w(CUENTA_PERSIST);

  estado_t         st, nxt;
  logic [CW-1:0]   cnt, cnt_n;
  logic            es_caliente, es_frio, llega;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= FRIO;
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      st  <= nxt;
      cnt <= cnt_n;
      // a set on this edge overrides a simultaneous clear
      if (!dato && dato_nxt) sticky <= 1'b1;
      else if (borrar)       sticky <= 1'b0;
    end
  end

  assign es_caliente = (temp >= alto);
  assign es_frio     = (temp < bajo_ef);
  assign llega       = ((cnt + CW'(1)) == CW'(CUENTA_PERSIST));

  always_comb begin
    nxt   = st;
    cnt_n = cnt;
    if (valida) begin
      unique case (st)
        FRIO: if (es_caliente) begin
          if (CUENTA_PERSIST == 1) begin nxt = CALIENTE; cnt_n = '0;     end
          else                     begin nxt = SUBIENDO; cnt_n = CW'(1); end
        end
        SUBIENDO: begin
          if (!es_caliente)  begin nxt = FRIO;     cnt_n = '0; end
          else if (llega)    begin nxt = CALIENTE; cnt_n = '0; end
          else               cnt_n = cnt + CW'(1);
        end
        CALIENTE: if (es_frio) begin
          if (CUENTA_PERSIST == 1) begin nxt = FRIO;    cnt_n = '0;     end
          else                     begin nxt = BAJANDO; cnt_n = CW'(1); end
        end
        BAJANDO: begin
          if (!es_frio)      begin nxt = CALIENTE; cnt_n = '0; end
          else if (llega)    begin nxt = FRIO;     cnt_n = '0; end
          else               cnt_n = cnt + CW'(1);
        end
        default: begin nxt = FRIO; cnt_n = '0; end
      endcase
    end
  end

  always_comb begin
    dato     = st[1];
    dato_nxt = nxt[1];
  end
endmodule

// File: rtl/comparador_umbral_hist.sv
// Multi-channel hysteresis comparator: shared thresholds, one filter per
// channel, and the aggregate any-hot / transition-pulse flags.
module comparador_umbral_hist
  import comparador_pkg::*;
#(
  parameter int ANCHO          = 3,
  parameter int N_CANALES      = 2,
  parameter int CUENTA_PERSIST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  comparador_umbral_hist_if.slave  bus
);
  logic [ANCHO-1:0]      bajo_ef;
  logic [N_CANALES-1:0]  dato, dato_nxt, sticky;
  logic                  cualquiera, evento;

  // bajo above alto collapses to zero hysteresis instead of oscillating
  assign bajo_ef = (bus.umbral_bajo < bus.umbral_alto) ? bus.umbral_bajo : bus.umbral_alto;

  for (genvar k = 0; k < N_CANALES; k++) begin : g_canal
    canal_histeresis #(
      .ANCHO          (ANCHO),
      .CUENTA_PERSIST (CUENTA_PERSIST)
    ) u_canal (
      .clk      (clk),
      .reset    (reset),
      .valida   (bus.muestra_valida),
      .temp     (bus.temp[k*ANCHO +: ANCHO]),
      .alto     (bus.umbral_alto),
      .bajo_ef  (bajo_ef),
      .borrar   (bus.borrar_sticky),
      .dato     (dato[k]),
      .dato_nxt (dato_nxt[k]),
      .sticky   (sticky[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cualquiera <= 1'b0;
      evento     <= 1'b0;
    end else begin
      cualquiera <= |dato_nxt;
      evento     <= |(dato_nxt ^ dato);
    end
  end

  assign bus.Dato_comp  = dato;
  assign bus.sticky     = sticky;
  assign bus.cualquiera = cualquiera;
  assign bus.evento     = evento;
endmodule
